mem_arb: RTL and testbench
==========================

Name: mem_arb

Overview:
- Parametrised N-channel memory-request arbiter that merges several requester channels onto one memory port.
- Typical use: CPU instruction-fetch and data-access paths sharing a single unified memory.
- Each cycle, grants at most one pending request, registers it into a one-entry output stage, and records the channel ID of each read.
- Read responses return in order; each is steered back to its originating channel using a tag FIFO.

Parameters:
- NUM_CH, 2, number of requester channels (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_OUTST, 4, maximum outstanding reads, including any read held in the output register (power of 2, >=2)

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- req_vld  in  NUM_CH  per-channel request valid
- req_rdy  out  NUM_CH  per-channel request accepted this cycle
- req_addr  in  NUM_CH*ADDR_W  flattened addresses; channel i at [i*ADDR_W +: ADDR_W]
- req_wen  in  NUM_CH  1=write, 0=read
- req_wdata  in  NUM_CH*DATA_W  flattened write data
- rsp_vld  out  NUM_CH  one-hot read-response valid
- rsp_rdata  out  DATA_W  read data, shared by all channels
- mem_req_vld  out  1  memory request valid
- mem_req_rdy  in  1  memory accepts request
- mem_req_addr  out  ADDR_W  memory address
- mem_req_wen  out  1  memory write enable
- mem_req_wdata  out  DATA_W  memory write data
- mem_rsp_vld  in  1  memory read-response valid (reads only; writes get no response)
- mem_rsp_rdata  in  DATA_W  memory read data
- err_orphan  out  1  sticky: response arrived with no outstanding read

Behaviour:
- Reset, asynchronous on resetn low: mem_req_vld=0, rsp_vld=0, rsp_rdata=0, err_orphan=0, rr_ptr=0, tag FIFO empty, occupancy=0. mem_req_addr/wen/wdata reset to 0.
- Reset mid-operation discards all in-flight state. Late memory responses after reset set err_orphan.
- Output stage:
  - load_en = (!mem_req_vld || mem_req_rdy) && |req_vld && !fifo_full.
  - A read is blocked while the FIFO is full. Writes are also blocked, keeping the grant logic uniform.
  - A pop in the same cycle does not relieve a full FIFO; the grant waits one cycle.
- Grant, combinational:
  - Round-robin search starting at rr_ptr; first channel with req_vld wins.
  - req_rdy[g]=load_en for the winner only; all other req_rdy bits are 0.
- On load: register the winner's addr/wen/wdata and set mem_req_vld=1.
  - rr_ptr <= (g+1) mod NUM_CH, wrapping from NUM_CH-1 to 0.
  - If wen=0, push g into the tag FIFO.
- Hold: while mem_req_vld && !mem_req_rdy, the output register holds stable. No new grants occur.
- Drain: mem_req_vld && mem_req_rdy && no load clears mem_req_vld. Accept-and-load in the same cycle gives back-to-back issue, one request per cycle.
- Latency: request accepted on req_rdy cycle N appears on the mem_req_* outputs at cycle N+1.
- Response path:
  - mem_rsp_vld at cycle M with FIFO non-empty gives rsp_vld[head]=1 and rsp_rdata=mem_rsp_rdata at cycle M+1, and pops the head.
  - Otherwise rsp_vld=0 and rsp_rdata holds its last value.
- Orphan response: mem_rsp_vld with the FIFO empty is dropped and sets err_orphan=1 until reset.
- Simultaneous push and pop: occupancy is unchanged and both take effect.
- Occupancy is a $clog2(MAX_OUTST)+1-bit counter. FIFO pointers wrap modulo MAX_OUTST.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest channel index wins. rr_ptr is removed and the search always starts at 0.
- Undefined: round-robin as specified above.
- All other behaviour is identical in both modes.

Decomposition:
- mem_arb_pkg holds:
  - chan_id_t, a logic [$clog2(NUM_CH_MAX)-1:0] with NUM_CH_MAX=8;
  - mem_req_t struct {addr, wen, wdata}, parametrised via localparams ADDR_W_DFLT/DATA_W_DFLT;
  - the grant helper function rr_pick(vld, ptr).
- Sub-module: mem_arb_tag_fifo, a synchronous FIFO of chan_id_t, depth MAX_OUTST, with push/pop/full/empty/head outputs.

Test Plan:
- Reset then idle: all outputs 0. Assert mem_rsp_vld=1 once -> err_orphan=1 from the next cycle and sticky.
- NUM_CH=2, both channels hold req_vld with reads and mem_req_rdy=1 -> grants alternate 0,1,0,1. mem_req_addr follows the channel addresses 0x100,0x200,0x104,0x204.
- mem_req_rdy=0 for 3 cycles with ch1 write addr 0x40 data 0xDEAD -> mem_req_* stable for 3 cycles, req_rdy=0 throughout, single issue once mem_req_rdy rises.
- MAX_OUTST=4, 4 reads granted with no responses -> 5th read stalls (req_rdy=0). One response returns -> stall released one cycle later; rsp_vld one-hot to the first requester.
- Interleaved reads ch0 (0x10), ch1 (0x20), ch0 (0x30); memory returns data 0xA,0xB,0xC -> rsp_vld sequence 01,10,01 with matching rsp_rdata, each one cycle after mem_rsp_vld.
- With MEM_ARB_FIXED_PRIO_EN and both channels continuously valid -> ch0 granted every cycle, ch1 never granted until ch0 deasserts req_vld.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and grant helper for the mem_arb memory-request arbiter
//
// Contents:
//   NUM_CH_MAX          upper bound on requester channels (sizes chan_id_t)
//   ADDR_W_DFLT/DATA_W_DFLT  default address/data widths used by mem_req_t
//   chan_id_t           channel identifier carried through the tag FIFO
//   mem_req_t           one memory request {addr, wen, wdata}
//   rr_pick(vld, ptr)   rotating first-valid search starting at ptr
package mem_arb_pkg;

  localparam int NUM_CH_MAX  = 8;
  localparam int ADDR_W_DFLT = 32;
  localparam int DATA_W_DFLT = 32;

  typedef logic [$clog2(NUM_CH_MAX)-1:0] chan_id_t;

  typedef struct packed {
    logic [ADDR_W_DFLT-1:0] addr;
    logic                   wen;
    logic [DATA_W_DFLT-1:0] wdata;
  } mem_req_t;

  // Searches all NUM_CH_MAX slots modulo NUM_CH_MAX. Channels above the real
  // channel count are zero in vld, so for any ptr below the channel count the
  // result equals a search modulo the real count.
  function automatic chan_id_t rr_pick(input logic [NUM_CH_MAX-1:0] vld, input chan_id_t ptr);
    chan_id_t idx;
    chan_id_t pick;
    logic     found;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_CH_MAX; i++) begin
      idx = ptr + chan_id_t'(i);
      if (!found && vld[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// rtl/mem_arb_tag_fifo.sv - synchronous FIFO of channel IDs for in-order read responses
//
// Ports:
//   clk, resetn      clock, asynchronous active-low reset
//   push, push_id    write one channel ID (ignored when full)
//   pop              discard the head entry (ignored when empty)
//   full, empty      status from the registered occupancy count
//   head             channel ID at the head of the queue
module mem_arb_tag_fifo
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     resetn,
  input  logic     push,
  input  chan_id_t push_id,
  input  logic     pop,
  output logic     full,
  output logic     empty,
  output chan_id_t head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  chan_id_t        slots [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  // Status comes from the registered count only, so a pop in the same cycle
  // never makes a full FIFO look non-full.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = slots[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= push_id;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - N-channel memory-request arbiter with one-entry output stage and tag-steered read responses
//
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   req_vld/req_rdy              per-channel request handshake (req_rdy one-hot on grant)
//   req_addr/req_wen/req_wdata   flattened per-channel request fields, channel i at [i*W +: W]
//   rsp_vld/rsp_rdata            one-hot read-response valid, shared read data
//   mem_req_*                    registered memory request port (valid/ready)
//   mem_rsp_vld/mem_rsp_rdata    in-order memory read responses
//   err_orphan                   sticky flag: response seen with no outstanding read
//
// Build option: MEM_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins)
// instead of round-robin.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_CH-1:0]        req_vld,
  output logic [NUM_CH-1:0]        req_rdy,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH-1:0]        req_wen,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata,
  output logic [NUM_CH-1:0]        rsp_vld,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     mem_req_vld,
  input  logic                     mem_req_rdy,
  output logic [ADDR_W-1:0]        mem_req_addr,
  output logic                     mem_req_wen,
  output logic [DATA_W-1:0]        mem_req_wdata,
  input  logic                     mem_rsp_vld,
  input  logic [DATA_W-1:0]        mem_rsp_rdata,
  output logic                     err_orphan
);

  logic [NUM_CH_MAX-1:0] vld_ext;
  chan_id_t              ptr;
  chan_id_t              gnt;
  chan_id_t              head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  load_en;
  logic                  push;
  logic                  pop;
  logic [ADDR_W-1:0]     sel_addr;
  logic                  sel_wen;
  logic [DATA_W-1:0]     sel_wdata;

  always_comb begin
    vld_ext             = '0;
    vld_ext[NUM_CH-1:0] = req_vld;
  end

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  chan_id_t rr_ptr;
  assign ptr = rr_ptr;

  // Pointer moves to the channel after the winner so it has lowest priority next.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr <= '0;
    end else if (load_en) begin
      rr_ptr <= (int'(gnt) == NUM_CH - 1) ? '0 : gnt + chan_id_t'(1);
    end
  end
`endif

  assign gnt = rr_pick(vld_ext, ptr);

  // Writes are throttled by a full tag FIFO as well, keeping one grant rule.
  assign load_en = (!mem_req_vld || mem_req_rdy) && (|req_vld) && !fifo_full;
  assign req_rdy = load_en ? (NUM_CH'(1) << gnt) : '0;

  always_comb begin
    sel_addr  = '0;
    sel_wen   = 1'b0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(gnt) == i) begin
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wen   = req_wen[i];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign push = load_en && !sel_wen;
  assign pop  = mem_rsp_vld && !fifo_empty;

  mem_arb_tag_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_tag_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (push),
    .push_id (gnt),
    .pop     (pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (head)
  );

  // Output stage: load on grant, otherwise hold while stalled, drop valid once drained.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_req_vld   <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wen   <= 1'b0;
      mem_req_wdata <= '0;
    end else if (load_en) begin
      mem_req_vld   <= 1'b1;
      mem_req_addr  <= sel_addr;
      mem_req_wen   <= sel_wen;
      mem_req_wdata <= sel_wdata;
    end else if (mem_req_rdy) begin
      mem_req_vld   <= 1'b0;
    end
  end

  // Response path: steer to the oldest outstanding requester; orphans only flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_vld    <= '0;
      rsp_rdata  <= '0;
      err_orphan <= 1'b0;
    end else begin
      rsp_vld <= pop ? (NUM_CH'(1) << head) : '0;
      if (pop) rsp_rdata <= mem_rsp_rdata;
      if (mem_rsp_vld && fifo_empty) err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - self-checking bench for mem_arb against a queue-based reference model
module tb_mem_arb;

  localparam int NUM_CH    = 2;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MAX_OUTST = 4;

  logic                     clk = 1'b0;
  logic                     resetn;
  logic [NUM_CH-1:0]        req_vld;
  logic [NUM_CH-1:0]        req_rdy;
  logic [NUM_CH*ADDR_W-1:0] req_addr;
  logic [NUM_CH-1:0]        req_wen;
  logic [NUM_CH*DATA_W-1:0] req_wdata;
  logic [NUM_CH-1:0]        rsp_vld;
  logic [DATA_W-1:0]        rsp_rdata;
  logic                     mem_req_vld;
  logic                     mem_req_rdy;
  logic [ADDR_W-1:0]        mem_req_addr;
  logic                     mem_req_wen;
  logic [DATA_W-1:0]        mem_req_wdata;
  logic                     mem_rsp_vld;
  logic [DATA_W-1:0]        mem_rsp_rdata;
  logic                     err_orphan;

  mem_arb #(
    .NUM_CH    (NUM_CH),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MAX_OUTST (MAX_OUTST)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .req_vld       (req_vld),
    .req_rdy       (req_rdy),
    .req_addr      (req_addr),
    .req_wen       (req_wen),
    .req_wdata     (req_wdata),
    .rsp_vld       (rsp_vld),
    .rsp_rdata     (rsp_rdata),
    .mem_req_vld   (mem_req_vld),
    .mem_req_rdy   (mem_req_rdy),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wen   (mem_req_wen),
    .mem_req_wdata (mem_req_wdata),
    .mem_rsp_vld   (mem_rsp_vld),
    .mem_rsp_rdata (mem_rsp_rdata),
    .err_orphan    (err_orphan)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: pending read owners, memory-side accepted reads, output stage.
  int          tags[$];
  logic [31:0] mem_q[$];
  logic        m_vld;
  logic [31:0] m_addr;
  logic        m_wen;
  logic [31:0] m_wdata;
  logic [1:0]  m_rsp;
  logic [31:0] m_rdata;
  logic        m_orphan;
  int          m_last;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state();
    check("mem_req_vld", 64'(mem_req_vld), 64'(m_vld));
    if (m_vld) begin
      check("mem_req_addr", 64'(mem_req_addr), 64'(m_addr));
      check("mem_req_wen", 64'(mem_req_wen), 64'(m_wen));
      check("mem_req_wdata", 64'(mem_req_wdata), 64'(m_wdata));
    end
    check("rsp_vld", 64'(rsp_vld), 64'(m_rsp));
    check("rsp_rdata", 64'(rsp_rdata), 64'(m_rdata));
    check("err_orphan", 64'(err_orphan), 64'(m_orphan));
  endtask

  task automatic model_reset();
    tags.delete();
    m_vld    = 1'b0;
    m_addr   = '0;
    m_wen    = 1'b0;
    m_wdata  = '0;
    m_rsp    = '0;
    m_rdata  = '0;
    m_orphan = 1'b0;
    m_last   = NUM_CH - 1;
  endtask

  // Entered at posedge+1; leaves at posedge+1 with reset released.
  // Memory-side pending reads survive so late responses become orphans.
  task automatic do_reset(input bit async_chk);
    resetn      = 1'b0;
    req_vld     = '0;
    req_addr    = '0;
    req_wen     = '0;
    req_wdata   = '0;
    mem_req_rdy = 1'b0;
    mem_rsp_vld = 1'b0;
    mem_rsp_rdata = '0;
    model_reset();
    if (async_chk) begin
      #1;
      check_state();
      check("rst_mem_req_addr", 64'(mem_req_addr), 64'h0);
    end
    @(negedge clk);
    check_state();
    check("rst_req_rdy", 64'(req_rdy), 64'h0);
    check("rst_mem_req_addr", 64'(mem_req_addr), 64'h0);
    check("rst_mem_req_wdata", 64'(mem_req_wdata), 64'h0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  // rmode: 0 no response, 1 respond if a read is pending, 2 random, 3 forced orphan pulse
  task automatic step(input logic [1:0] vld, input logic [31:0] a0, input logic [31:0] a1,
                      input logic [1:0] wen, input logic [31:0] wd0, input logic [31:0] wd1,
                      input logic mrdy, input int rmode);
    logic [31:0] a [2];
    logic [31:0] wd [2];
    logic [1:0]  exp_rdy;
    int          g;
    int          ch;
    a[0] = a0; a[1] = a1; wd[0] = wd0; wd[1] = wd1;
    req_vld     = vld;
    req_addr    = {a1, a0};
    req_wen     = wen;
    req_wdata   = {wd1, wd0};
    mem_req_rdy = mrdy;
    mem_rsp_vld = 1'b0;
    mem_rsp_rdata = '0;
    if (rmode == 3) begin
      mem_rsp_vld   = 1'b1;
      mem_rsp_rdata = 32'h77;
    end else if (mem_q.size() > 0 && (rmode == 1 || (rmode == 2 && $urandom_range(2) == 0))) begin
      mem_rsp_vld   = 1'b1;
      mem_rsp_rdata = mem_q.pop_front() ^ 32'h5A5A_0000;
    end

    g = -1;
    if (!(m_vld && !mrdy) && tags.size() < MAX_OUTST) begin
      for (int k = 1; k <= NUM_CH; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        ch = k - 1;
`else
        ch = (m_last + k) % NUM_CH;
`endif
        if (g < 0 && vld[ch[0]]) g = ch;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g[0]] = 1'b1;

    @(negedge clk);
    check_state();
    check("req_rdy", 64'(req_rdy), 64'(exp_rdy));

    // Advance the model across the coming edge.
    m_rsp = '0;
    if (mem_rsp_vld) begin
      if (tags.size() > 0) begin
        ch = tags.pop_front();
        m_rsp[ch[0]] = 1'b1;
        m_rdata = mem_rsp_rdata;
      end else begin
        m_orphan = 1'b1;
      end
    end
    if (m_vld && mrdy && !m_wen) mem_q.push_back(m_addr);
    if (g >= 0) begin
      m_vld   = 1'b1;
      m_addr  = a[g[0]];
      m_wen   = wen[g[0]];
      m_wdata = wd[g[0]];
      if (!wen[g[0]]) tags.push_back(g);
      m_last  = g;
    end else if (mrdy) begin
      m_vld = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input int rmode);
    for (int i = 0; i < n; i++) step(2'b00, 32'h0, 32'h0, 2'b00, 32'h0, 32'h0, 1'b1, rmode);
  endtask

  initial begin
    resetn = 1'b1;
    #1;
    do_reset(1'b0);

    // Idle, then one orphan response; flag must stick.
    idle(2, 0);
    step(2'b00, 32'h0, 32'h0, 2'b00, 32'h0, 32'h0, 1'b1, 3);
    idle(3, 0);
    do_reset(1'b1);

    // Both channels reading continuously.
    step(2'b11, 32'h100, 32'h200, 2'b00, 32'h0, 32'h0, 1'b1, 1);
    step(2'b11, 32'h104, 32'h200, 2'b00, 32'h0, 32'h0, 1'b1, 1);
    step(2'b11, 32'h104, 32'h204, 2'b00, 32'h0, 32'h0, 1'b1, 1);
    step(2'b11, 32'h108, 32'h204, 2'b00, 32'h0, 32'h0, 1'b1, 1);
    step(2'b11, 32'h108, 32'h208, 2'b00, 32'h0, 32'h0, 1'b1, 1);
    idle(8, 1);

    // Back-pressure on a write from ch1.
    step(2'b10, 32'h0, 32'h40, 2'b10, 32'h0, 32'hDEAD, 1'b0, 0);
    for (int i = 0; i < 3; i++) step(2'b10, 32'h0, 32'h40, 2'b10, 32'h0, 32'hDEAD, 1'b0, 0);
    step(2'b00, 32'h0, 32'h0, 2'b00, 32'h0, 32'h0, 1'b1, 0);
    idle(2, 0);

    // Outstanding-read limit, then release by one response.
    for (int i = 0; i < 6; i++)
      step(2'b01, 32'h500 + 32'(4 * i), 32'h0, 2'b00, 32'h0, 32'h0, 1'b1, 0);
    step(2'b01, 32'h600, 32'h0, 2'b00, 32'h0, 32'h0, 1'b1, 1);
    step(2'b01, 32'h600, 32'h0, 2'b00, 32'h0, 32'h0, 1'b1, 0);
    idle(10, 1);

    // Interleaved reads with in-order steering.
    step(2'b01, 32'h10, 32'h0, 2'b00, 32'h0, 32'h0, 1'b1, 0);
    step(2'b10, 32'h0, 32'h20, 2'b00, 32'h0, 32'h0, 1'b1, 0);
    step(2'b01, 32'h30, 32'h0, 2'b00, 32'h0, 32'h0, 1'b1, 0);
    idle(6, 1);

    // Random traffic with a reset in the middle.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset(1'b1);
      step(2'($urandom), $urandom, $urandom, 2'($urandom_range(3) == 0 ? 2'($urandom) : 2'b00),
           $urandom, $urandom, 1'($urandom_range(9) < 7), 2);
    end
    idle(12, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
